// File: rtl/arb8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
package arb8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index arithmetic wraps naturally at IDX_W bits, so 7 + 1 becomes 0.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating first-one search: finds the first set request bit starting at ptr.
module rr_pick8
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N_REQ-1:0] reqTwice;
    logic [N_REQ-1:0]   reqRot;
    logic [IDX_W-1:0]   offset;

    // Rotate so bit 0 is req[ptr]; the lowest set bit is then the winner's distance from ptr.
    always_comb begin
        reqTwice = {req, req};
        reqRot   = N_REQ'(reqTwice >> ptr);
        offset   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (reqRot[i]) begin
                offset = IDX_W'(i);
            end
        end
        any = |req;
        idx = ptr + offset;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with bounded hold time and a mandatory idle gap.
module rr_arbiter8
    import arb8_pkg::*;
#(
    parameter  int MAX_HOLD = 16,
    localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             hold_expired
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic             hold_q, hold_d;

    logic [IDX_W-1:0] pickIdx;
    logic             pickAny;
    logic             timeout;
    logic             release_now;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pickIdx),
        .any (pickAny)
    );

    assign timeout     = (cnt_q == MAX_CNT);
    assign release_now = (state_q == GRANT) && (!req[idx_q] || timeout);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pickAny)     state_d = GRANT;
            GRANT:   if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; other requests are ignored while granted.
    always_comb begin
        ptr_d  = ptr_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        hold_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pickAny) begin
                    idx_d = pickIdx;
                    cnt_d = CNT_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d  = idx_inc(idx_q);
                    idx_d  = '0;
                    cnt_d  = '0;
                    hold_d = req[idx_q] && timeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                idx_d = '0;
                cnt_d = '0;
            end
        endcase
        valid_d = (state_d == GRANT);
        gnt_d   = valid_d ? (N_REQ'(1) << idx_d) : '0;
    end

    assign gnt          = gnt_q;
    assign gnt_idx      = idx_q;
    assign gnt_valid    = valid_q;
    assign hold_expired = hold_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a cycle-level reference model predicts outputs, a monitor compares.
module tb_rr_arbiter8;

    localparam int MH = 4;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       expired;
    } expT;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       hold_expired;

    expT sb[$];
    int  orderLog[$];
    int  checkCount = 0;
    int  errCount   = 0;

    // Reference model state: who owns the resource, how long, and where the search starts.
    int owner    = -1;
    int held     = 0;
    int nextPrio = 0;
    bit expFlag  = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .gnt          (gnt),
        .gnt_idx      (gnt_idx),
        .gnt_valid    (gnt_valid),
        .hold_expired (hold_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    always @(posedge clk) begin
        expT e;
        if (!rst_n) begin
            owner    = -1;
            held     = 0;
            nextPrio = 0;
            expFlag  = 1'b0;
        end else if (owner < 0) begin
            expFlag = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (nextPrio + k) % 8;
                if (owner < 0 && req[c]) begin
                    owner = c;
                    held  = 1;
                end
            end
        end else if (!req[owner] || held == MH) begin
            expFlag  = req[owner] ? 1'b1 : 1'b0;
            nextPrio = (owner + 1) % 8;
            owner    = -1;
            held     = 0;
        end else begin
            held++;
        end
        e.gnt     = (owner >= 0) ? 8'(1 << owner) : 8'h00;
        e.idx     = (owner >= 0) ? 3'(owner) : 3'd0;
        e.valid   = (owner >= 0);
        e.expired = expFlag;
        sb.push_back(e);
    end

    always @(negedge clk) begin
        static bit prevValid = 1'b0;
        expT e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("gnt", 32'(gnt), 32'(e.gnt));
            checkOutput("gnt_idx", 32'(gnt_idx), 32'(e.idx));
            checkOutput("gnt_valid", 32'(gnt_valid), 32'(e.valid));
            checkOutput("hold_expired", 32'(hold_expired), 32'(e.expired));
            checkOutput("onehot_valid", 32'($onehot0(gnt) && ((gnt != 8'h00) == gnt_valid)), 32'd1);
            if (gnt_valid && !prevValid) orderLog.push_back(int'(gnt_idx));
            prevValid = gnt_valid;
        end
    end

    task automatic applyStimulus(input logic [7:0] r, input logic rn, input int cycles);
        req   = r;
        rst_n = rn;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        req   = 8'hFF;
        rst_n = 1'b0;
        applyStimulus(8'hFF, 1'b0, 3);
        applyStimulus(8'hFF, 1'b1, 2);
        applyStimulus(8'h00, 1'b1, 2);

        applyStimulus(8'h20, 1'b1, 5);
        applyStimulus(8'h00, 1'b1, 2);
        applyStimulus(8'h41, 1'b1, 3);
        applyStimulus(8'h00, 1'b1, 2);

        applyStimulus(8'hFF, 1'b0, 1);
        orderLog.delete();
        applyStimulus(8'hFF, 1'b1, 45);
        checkOutput("rotation_len", 32'(orderLog.size() >= 9), 32'd1);
        for (int i = 0; i < 9 && i < orderLog.size(); i++) begin
            checkOutput("rotation_order", 32'(orderLog[i]), 32'(i % 8));
        end
        applyStimulus(8'h00, 1'b1, 2);

        applyStimulus(8'h08, 1'b1, 3 * (MH + 1) + 2);
        applyStimulus(8'h00, 1'b1, 2);

        applyStimulus(8'h80, 1'b1, 3);
        applyStimulus(8'h00, 1'b1, 1);
        applyStimulus(8'h81, 1'b1, 2);
        applyStimulus(8'h00, 1'b1, 1);
        applyStimulus(8'h81, 1'b1, 2);
        applyStimulus(8'h00, 1'b1, 2);

        applyStimulus(8'h10, 1'b1, 3);
        applyStimulus(8'h10, 1'b0, 1);
        applyStimulus(8'h11, 1'b1, 3);
        applyStimulus(8'h00, 1'b1, 2);

        for (int n = 0; n < 120; n++) begin
            logic [7:0] r;
            logic       rn;
            r  = (n % 3 == 0) ? 8'($urandom & $urandom) : 8'($urandom);
            rn = ($urandom_range(0, 39) != 0);
            applyStimulus(r, rn, int'($urandom_range(1, 8)));
        end

        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Selects a winner index (3 bits), holds the grant under a handshake, and drives a one-hot grant vector via a 3-to-8 decode.
- Sits in front of any shared 8-way resource (bus, memory port, output mux) and schedules access fairly with a bounded hold time.

Parameters:
- MAX_HOLD, 16, max consecutive cycles a single grant may be held; legal range 1..256.
- CNT_W, $clog2(MAX_HOLD+1), hold counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- req  input  8  request vector; bit i = requester i wants the resource
- gnt  output  8  one-hot grant; all-zero when no grant
- gnt_idx  output  3  index of current grantee; 0 when gnt_valid=0
- gnt_valid  output  1  high while any grant is active
- hold_expired  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD timeout

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, gnt=8'h00, gnt_idx=0, gnt_valid=0, hold_expired=0, ptr=0, cnt=0.
  - Reset mid-grant drops the grant on the next edge; no grace cycle.
- All outputs are registered. There is no combinational path from req to gnt.
- State IDLE:
  - gnt=0.
  - If req!=0: winner = first set bit of req, searching ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod-8 wrap).
  - Next edge: state=GRANT, gnt_idx=winner, gnt=1<<winner, gnt_valid=1, cnt=1.
  - If req==0: stay IDLE.
- Latency: req sampled high in an IDLE cycle -> gnt visible in the following cycle (1 cycle).
- State GRANT, on each edge:
  - If req[gnt_idx]==0: release. State=IDLE, gnt=0, gnt_valid=0, ptr=gnt_idx+1 (7 wraps to 0), hold_expired=0.
  - Else if cnt==MAX_HOLD: timeout. Same as release, plus hold_expired=1 for exactly one cycle.
  - Else: cnt=cnt+1; grant unchanged.
- A requester holds the grant for at most MAX_HOLD cycles. With MAX_HOLD=1, every grant lasts exactly 1 cycle.
- Changes to other req bits during GRANT are ignored. No preemption.
- Every grant is followed by at least one IDLE cycle with gnt=0. This is the bus-turnaround gap.
- A requester that drops and re-asserts req in that IDLE cycle competes normally. Its priority is lowest because ptr has moved past it.
- Fairness: with all 8 requesting continuously, grants go 0,1,2,...,7,0,... Each requester waits at most 7 grant periods plus gaps.
- gnt is always the 3-to-8 one-hot decode of gnt_idx, gated by gnt_valid. Invariant: $onehot0(gnt), and gnt!=0 iff gnt_valid.
- cnt saturates logically at MAX_HOLD and never wraps.

Decomposition:
- Package arb8_pkg holds:
  - N_REQ=8, IDX_W=3
  - state enum {IDLE, GRANT}
  - a function that increments an IDX_W-bit index mod 8
- Sub-module rr_pick8, combinational:
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: idx[2:0], any.
  - Implements the rotating first-one search.
- The top holds the FSM, counter, pointer, and output registers.
- The one-hot gnt is a 3-to-8 decode of gnt_idx. The team's existing 3-to-8 decoder may be instantiated for it.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=8'hFF -> gnt=0, gnt_valid=0, gnt_idx=0 throughout. After release, first grant is gnt=8'h01 one cycle later.
- Single requester: req=8'h20, dropped after 4 cycles of grant -> gnt=8'h20 and gnt_idx=5 for 4 cycles, then gnt=0 for ≥1 cycle. ptr=6, so with req=8'h41 next, req 6 wins (gnt=8'h40).
- Full rotation: req=8'hFF held with MAX_HOLD=2 -> grant order idx 0..7 then 0. Each grant lasts 2 cycles, each is followed by a 1-cycle gap, and hold_expired pulses once per grant.
- Timeout: MAX_HOLD=16, req=8'h08 held forever -> gnt=8'h08 for exactly 16 cycles, hold_expired=1 in the first gap cycle, re-grant to idx 3 the cycle after.
- Wrap priority: after a grant to idx 7 ends, req=8'h81 -> idx 0 wins (ptr wrapped to 0). Then with req=8'h81 again -> idx 7 wins (ptr=1).
- Reset mid-grant: assert rst_n=0 during a grant to idx 4 -> gnt=0 on the next edge and ptr=0. After release with req=8'h11, idx 0 wins.
